// File: rtl/pixel_packer.sv
// pixel_packer: packs a serial 24-bit RGB pixel stream into 32-bit
// AXI4-Stream words (4 pixels -> 3 words) with frame/line markers.
//
// Ports:
//   aclk, aresetn     clock, asynchronous active-low reset
//   clear             synchronous restart of phase/x/y/residual
//   in_r/in_g/in_b    pixel colour components (pixel = {r,g,b})
//   in_valid          pixel present this cycle
//   in_ready          packer can take a pixel this cycle (combinational)
//   m_axis_tdata      packed output word
//   m_axis_tvalid     output word valid
//   m_axis_tready     sink ready
//   m_axis_tlast      word holds last pixel of a line
//   m_axis_tuser      word holds pixel (0,0) of a frame
//   frame_done        one-cycle pulse after the last word of a frame is taken
module pixel_packer #(
  parameter int unsigned X_SIZE = 640,
  parameter int unsigned Y_SIZE = 480
) (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic        clear,
  input  logic [7:0]  in_r,
  input  logic [7:0]  in_g,
  input  logic [7:0]  in_b,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [31:0] m_axis_tdata,
  output logic        m_axis_tvalid,
  input  logic        m_axis_tready,
  output logic        m_axis_tlast,
  output logic        m_axis_tuser,
  output logic        frame_done
);

  localparam int unsigned PW = 24;
  localparam int unsigned DW = 32;
  localparam int unsigned XW = (X_SIZE > 1) ? $clog2(X_SIZE) : 1;
  localparam int unsigned YW = (Y_SIZE > 1) ? $clog2(Y_SIZE) : 1;

  typedef enum logic [1:0] {PH0, PH1, PH2, PH3} phase_e;

  phase_e          phase_q, phase_d;
  logic [XW-1:0]   x_q, x_d;
  logic [YW-1:0]   y_q, y_d;
  logic [PW-1:0]   residual_q, residual_d;
  logic            sof_q, sof_d;       // current group started at pixel (0,0)
  logic [DW-1:0]   tdata_q, tdata_d;
  logic            tvalid_q, tvalid_d;
  logic            tlast_q, tlast_d;
  logic            tuser_q, tuser_d;
  logic            eof_q, eof_d;       // held word is the last word of a frame
  logic            frame_done_q, frame_done_d;

  logic [PW-1:0]   pixel;
  logic            accept;
  logic            line_end;
  logic            frame_end;

  // Ready whenever the output slot is empty or draining this cycle.
  assign in_ready = aresetn && (!tvalid_q || m_axis_tready);

  assign m_axis_tdata  = tdata_q;
  assign m_axis_tvalid = tvalid_q;
  assign m_axis_tlast  = tlast_q;
  assign m_axis_tuser  = tuser_q;
  assign frame_done    = frame_done_q;

  // State registers.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      phase_q      <= PH0;
      x_q          <= '0;
      y_q          <= '0;
      residual_q   <= '0;
      sof_q        <= 1'b0;
      tdata_q      <= '0;
      tvalid_q     <= 1'b0;
      tlast_q      <= 1'b0;
      tuser_q      <= 1'b0;
      eof_q        <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      phase_q      <= phase_d;
      x_q          <= x_d;
      y_q          <= y_d;
      residual_q   <= residual_d;
      sof_q        <= sof_d;
      tdata_q      <= tdata_d;
      tvalid_q     <= tvalid_d;
      tlast_q      <= tlast_d;
      tuser_q      <= tuser_d;
      eof_q        <= eof_d;
      frame_done_q <= frame_done_d;
    end
  end

  // Phase FSM, position counters and output stage.
  always_comb begin
    pixel     = {in_r, in_g, in_b};
    accept    = in_valid && in_ready && !clear;
    line_end  = (x_q == XW'(X_SIZE - 1));
    frame_end = (y_q == YW'(Y_SIZE - 1));

    phase_d      = phase_q;
    x_d          = x_q;
    y_d          = y_q;
    residual_d   = residual_q;
    sof_d        = sof_q;
    tdata_d      = tdata_q;
    tlast_d      = tlast_q;
    tuser_d      = tuser_q;
    eof_d        = eof_q;
    // Slot empties on a handshake unless reloaded below.
    tvalid_d     = tvalid_q && !m_axis_tready;
    frame_done_d = tvalid_q && m_axis_tready && eof_q;

    if (clear) begin
      phase_d    = PH0;
      x_d        = '0;
      y_d        = '0;
      residual_d = '0;
      sof_d      = 1'b0;
    end else if (accept) begin
      if (line_end) begin
        x_d = '0;
        y_d = frame_end ? '0 : y_q + YW'(1);
      end else begin
        x_d = x_q + XW'(1);
      end

      unique case (phase_q)
        PH0: begin
          residual_d = pixel;
          sof_d      = (x_q == '0) && (y_q == '0);
          phase_d    = PH1;
        end
        PH1: begin
          tdata_d    = {pixel[7:0], residual_q};
          tvalid_d   = 1'b1;
          tuser_d    = sof_q;
          tlast_d    = 1'b0;
          eof_d      = 1'b0;
          residual_d = {8'h00, pixel[23:8]};
          phase_d    = PH2;
        end
        PH2: begin
          tdata_d    = {pixel[15:0], residual_q[15:0]};
          tvalid_d   = 1'b1;
          tuser_d    = 1'b0;
          tlast_d    = 1'b0;
          eof_d      = 1'b0;
          residual_d = {16'h0000, pixel[23:16]};
          phase_d    = PH3;
        end
        PH3: begin
          tdata_d    = {pixel, residual_q[7:0]};
          tvalid_d   = 1'b1;
          tuser_d    = 1'b0;
          tlast_d    = line_end;
          eof_d      = line_end && frame_end;
          residual_d = '0;
          phase_d    = PH0;
        end
        default: phase_d = PH0;
      endcase
    end
  end

endmodule

// File: tb/tb_pixel_packer.sv
// Bench for pixel_packer: behavioural group model + per-cycle compare,
// directed scenarios with literal expectations, then random traffic.
module tb_pixel_packer;

  localparam int unsigned X = 8;
  localparam int unsigned Y = 2;

  logic        aclk = 1'b0;
  logic        aresetn;
  logic        clear;
  logic [7:0]  in_r, in_g, in_b;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tready;
  logic        m_axis_tlast;
  logic        m_axis_tuser;
  logic        frame_done;

  pixel_packer #(.X_SIZE(X), .Y_SIZE(Y)) dut (
    .aclk(aclk), .aresetn(aresetn), .clear(clear),
    .in_r(in_r), .in_g(in_g), .in_b(in_b),
    .in_valid(in_valid), .in_ready(in_ready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast),
    .m_axis_tuser(m_axis_tuser), .frame_done(frame_done)
  );

  always #5 aclk = ~aclk;

  typedef struct packed {
    logic [31:0] d;
    logic        l;
    logic        u;
    logic        e;
  } exp_t;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: pixel index within the frame and the pixels of the current group.
  exp_t        q[$];
  int          pix_idx = 0;
  int          gpos = 0;
  logic [95:0] grp = '0;
  logic        fd_exp = 1'b0;

  // Observation log of taken words for the directed literal checks.
  logic [33:0] log_q[$];
  int          fd_cnt = 0;
  int          rdy_low = 0;

  logic        prev_stall = 1'b0;
  logic [33:0] prev_word;

  function automatic void model_restart();
    pix_idx = 0;
    gpos    = 0;
    grp     = '0;
  endfunction

  function automatic void model_accept(input logic [23:0] p);
    exp_t e;
    int   start;
    if (gpos == 0) grp = '0;
    grp[gpos*24 +: 24] = p;
    if (gpos > 0) begin
      // Words are successive 32-bit slices of the little-endian 96-bit group.
      start = pix_idx - gpos;
      e.d = grp[(gpos-1)*32 +: 32];
      e.u = (gpos == 1) && (start == 0);
      e.l = (gpos == 3) && ((pix_idx % X) == X - 1);
      e.e = (gpos == 3) && (pix_idx == X * Y - 1);
      q.push_back(e);
    end
    pix_idx = (pix_idx + 1) % (X * Y);
    gpos    = (gpos + 1) % 4;
  endfunction

  // Compare process: sample mid-cycle, outputs and inputs are stable.
  always @(negedge aclk) begin
    exp_t e;
    if (!aresetn) begin
      chk("rst_tvalid", 64'(m_axis_tvalid), 64'd0);
      chk("rst_tdata", 64'(m_axis_tdata), 64'd0);
      chk("rst_tlast", 64'(m_axis_tlast), 64'd0);
      chk("rst_tuser", 64'(m_axis_tuser), 64'd0);
      chk("rst_fd", 64'(frame_done), 64'd0);
      chk("rst_in_ready", 64'(in_ready), 64'd0);
      q.delete();
      model_restart();
      fd_exp     = 1'b0;
      prev_stall = 1'b0;
    end else begin
      chk("tvalid", 64'(m_axis_tvalid), 64'(q.size() != 0));
      chk("in_ready", 64'(in_ready), 64'(!m_axis_tvalid || m_axis_tready));
      chk("frame_done", 64'(frame_done), 64'(fd_exp));
      if (frame_done) fd_cnt++;
      if (in_valid && !in_ready) rdy_low++;
      fd_exp = 1'b0;
      if (prev_stall)
        chk("hold", {30'd0, m_axis_tuser, m_axis_tlast, m_axis_tdata}, 64'(prev_word));
      prev_stall = m_axis_tvalid && !m_axis_tready;
      prev_word  = {m_axis_tuser, m_axis_tlast, m_axis_tdata};
      if (m_axis_tvalid && m_axis_tready) begin
        if (q.size() == 0) begin
          chk("unexpected_word", 64'(m_axis_tdata), 64'hxdead);
        end else begin
          e = q.pop_front();
          chk("tdata", 64'(m_axis_tdata), 64'(e.d));
          chk("tlast", 64'(m_axis_tlast), 64'(e.l));
          chk("tuser", 64'(m_axis_tuser), 64'(e.u));
          fd_exp = e.e;
        end
        log_q.push_back({m_axis_tuser, m_axis_tlast, m_axis_tdata});
      end
      if (clear) model_restart();
      else if (in_valid && in_ready) model_accept({in_r, in_g, in_b});
    end
  end

  task automatic send(input logic [23:0] p);
    {in_r, in_g, in_b} = p;
    in_valid = 1'b1;
    @(posedge aclk); #1;
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) begin @(posedge aclk); #1; end
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    @(posedge aclk); #1;
    clear = 1'b0;
  endtask

  task automatic chk_log(input string name, input int idx, input logic [33:0] exp);
    if (idx >= log_q.size()) chk(name, 64'hffff_ffff_ffff_ffff, 64'(exp));
    else chk(name, 64'(log_q[idx]), 64'(exp));
  endtask

  initial begin
    logic [23:0] p;
    aresetn = 1'b0; clear = 1'b0; in_valid = 1'b0;
    in_r = '0; in_g = '0; in_b = '0; m_axis_tready = 1'b1;
    repeat (3) @(posedge aclk);
    #1 aresetn = 1'b1;
    idle(1);

    // Basic packing.
    log_q.delete();
    send(24'h112233); send(24'h445566); send(24'h778899); send(24'hAABBCC);
    idle(3);
    chk("basic_cnt", 64'(log_q.size()), 64'd3);
    chk_log("basic_w0", 0, {2'b10, 32'h66112233});
    chk_log("basic_w1", 1, {2'b00, 32'h88994455});
    chk_log("basic_w2", 2, {2'b00, 32'hAABBCC77});

    // Full frame back-to-back: line/frame markers and 1 pixel/cycle.
    pulse_clear();
    log_q.delete(); fd_cnt = 0; rdy_low = 0;
    for (int i = 0; i < 16; i++) begin
      {in_r, in_g, in_b} = 24'(i + 1);
      in_valid = 1'b1;
      @(posedge aclk); #1;
    end
    idle(4);
    chk("frame_cnt", 64'(log_q.size()), 64'd12);
    chk("b2b_ready", 64'(rdy_low), 64'd0);
    chk("frame_done_cnt", 64'(fd_cnt), 64'd1);
    for (int k = 0; k < 12 && k < log_q.size(); k++) begin
      chk("frame_tlast", 64'(log_q[k][32]), 64'(k == 5 || k == 11));
      chk("frame_tuser", 64'(log_q[k][33]), 64'(k == 0));
    end
    // Pixels 1,2 pack to {02, 000001}.
    chk_log("frame_w0", 0, {2'b10, 32'h02000001});
    log_q.delete();
    send(24'h0000AA); send(24'h0000BB);
    idle(2);
    chk_log("next_frame_sof", 0, {2'b10, 32'hBB0000AA});
    idle(1); send(24'h0); send(24'h0); idle(2);

    // Backpressure stall and release.
    pulse_clear();
    log_q.delete();
    send(24'h123456); send(24'h789ABC);
    m_axis_tready = 1'b0;
    {in_r, in_g, in_b} = 24'hDEF012;
    in_valid = 1'b1;
    repeat (4) begin
      @(negedge aclk);
      chk("bp_in_ready", 64'(in_ready), 64'd0);
      chk("bp_tvalid", 64'(m_axis_tvalid), 64'd1);
      chk("bp_tdata", 64'(m_axis_tdata), 64'hBC123456);
    end
    m_axis_tready = 1'b1;
    @(posedge aclk); #1;
    send(24'h345678);
    idle(3);
    chk("bp_cnt", 64'(log_q.size()), 64'd3);
    chk_log("bp_w0", 0, {2'b10, 32'hBC123456});
    chk_log("bp_w1", 1, {2'b00, 32'hF012789A});
    chk_log("bp_w2", 2, {2'b00, 32'h345678DE});

    // Clear mid-line with a pixel offered in the clear cycle.
    pulse_clear();
    log_q.delete();
    send(24'h010203); send(24'h040506);
    {in_r, in_g, in_b} = 24'hDEADBE;
    in_valid = 1'b1; clear = 1'b1;
    @(posedge aclk); #1;
    clear = 1'b0; in_valid = 1'b0;
    send(24'h0A0B0C); send(24'h0D0E0F); send(24'h101112); send(24'h131415);
    idle(3);
    chk("clr_cnt", 64'(log_q.size()), 64'd4);
    chk_log("clr_w0", 0, {2'b10, 32'h06010203});
    chk_log("clr_w1", 1, {2'b10, 32'h0F0A0B0C});

    // Asynchronous reset with a word pending.
    pulse_clear();
    m_axis_tready = 1'b0;
    send(24'hAAAAAA); send(24'hBBBBBB);
    @(negedge aclk);
    chk("pre_rst_tvalid", 64'(m_axis_tvalid), 64'd1);
    @(posedge aclk); #3;
    aresetn = 1'b0;
    #1;
    chk("arst_tvalid", 64'(m_axis_tvalid), 64'd0);
    chk("arst_tdata", 64'(m_axis_tdata), 64'd0);
    chk("arst_flags", {62'd0, m_axis_tlast, m_axis_tuser}, 64'd0);
    chk("arst_in_ready", 64'(in_ready), 64'd0);
    repeat (2) @(posedge aclk);
    #1 aresetn = 1'b1;
    m_axis_tready = 1'b1;
    log_q.delete();
    send(24'h102030); send(24'h405060); send(24'h708090); send(24'hA0B0C0);
    idle(3);
    chk_log("post_rst_w0", 0, {2'b10, 32'h60102030});
    chk_log("post_rst_w2", 2, {2'b00, 32'hA0B0C070});

    // Random traffic with backpressure and occasional clear.
    for (int i = 0; i < 3000; i++) begin
      p = 24'($urandom);
      {in_r, in_g, in_b} = p;
      in_valid      = ($urandom_range(0, 3) != 0);
      m_axis_tready = ($urandom_range(0, 9) < 7);
      clear         = ($urandom_range(0, 99) == 0);
      @(posedge aclk); #1;
    end
    clear = 1'b0; in_valid = 1'b0; m_axis_tready = 1'b1;
    idle(5);
    chk("drain_empty", 64'(q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
